mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single memory port (block-wide data bus, readM/writeM/input_readyM/doneM handshake) between the instruction-side and data-side cache instances.
- Arbitrates with round-robin priority and holds each grant for one complete memory transaction.
- Routes address, data and status to and from the current owner only.
- Sits between the two cache instances and the memory model; keeps grant and wait statistics for the performance counters.

Parameters:
WORD_SIZE, 16, processor word / address width
READ_SIZE, 64, memory block bus width (4 words)

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
i_readM  input  1  I-side memory read request
i_writeM  input  1  I-side memory write request
i_address  input  WORD_SIZE  I-side address
i_wdata  input  READ_SIZE  I-side write data
i_rdata  output  READ_SIZE  read data to I-side
i_input_readyM  output  1  memory read-ready, I-side copy
i_doneM  output  1  memory write-done, I-side copy
d_readM, d_writeM, d_address, d_wdata, d_rdata, d_input_readyM, d_doneM  same as I-side, for D-side
readM  output  1  memory read strobe
writeM  output  1  memory write strobe
address  output  WORD_SIZE  memory address
dataM  inout  READ_SIZE  memory data bus
input_readyM  input  1  memory read data valid
doneM  input  1  memory write complete
grant  output  2  2'b00 none, 2'b01 I-side, 2'b10 D-side
num_grant_i  output  WORD_SIZE  I-side grants issued
num_grant_d  output  WORD_SIZE  D-side grants issued
num_wait  output  WORD_SIZE  cycles any requester was pending but not granted

Behaviour:
- States: IDLE, OWN_I, OWN_D. Register `last` records the side served most recently; reset value D, so I wins the first tie.
- Reset: synchronous on posedge clk with reset_n low. State IDLE, `last`=D, all counters 0. Combinational outputs then resolve to: readM=writeM=0, grant=00, address=0, i/d status outputs 0, rdata outputs 0, dataM high-Z.
- A side's request is req_x = x_readM | x_writeM.
- IDLE transitions:
  - Only one side requesting: go to that side's OWN state.
  - Both requesting: go to the side opposite `last`.
  - On entering OWN_x: set `last`=x and increment num_grant_x.
- Arbitration latency: exactly one cycle. In the request cycle the memory sees nothing; the strobe appears the cycle after.
- OWN_x outputs, all combinational from state:
  - readM=x_readM, writeM=x_writeM, address=x_address.
  - dataM driven with x_wdata only when writeM=1, otherwise high-Z.
  - x_rdata=dataM; x_input_readyM=input_readyM; x_doneM=doneM.
  - The non-owner sees rdata=0, input_readyM=0, doneM=0, so memory status never leaks to it.
- Release: in OWN_x, on the first clock edge where req_x=0, return to IDLE. Caches drop their strobe when input_readyM/doneM arrives, so the grant ends one edge after completion.
  - No direct OWN_I to OWN_D hop: a pending other side is granted from IDLE on the following edge.
  - Minimum gap between transactions is one IDLE cycle.
- Owner re-request: a cache that issues readM then writeM back-to-back (write miss) keeps req_x high continuously and keeps the grant. No preemption.
- num_wait: increments each cycle that a non-owned side has req=1. In IDLE with both requesting, it counts +1 for the loser.
- Counters wrap modulo 2^WORD_SIZE.
- Both x_readM and x_writeM high together is illegal. Arbiter passes both through unchanged; the bench flags it with an assertion.
- Reset mid-transaction: returns to IDLE and drops the strobes combinationally on the next edge. The memory model's own reset is responsible for aborting.

Test Plan:
1. Reset, then I-side read at 0x0040 alone -> grant=01 one cycle later, readM=1, address=0x0040; memory input_readyM with dataM=64'h0004_0003_0002_0001 -> i_rdata matches, d_input_readyM stays 0; num_grant_i=1.
2. I and D request in the same cycle right after reset -> I granted first (`last`=D at reset). After I releases: one IDLE cycle, then grant=10. num_wait counts D's waiting cycles exactly; num_grant_d=1.
3. Continuous dual requests over 6 transactions -> grants alternate I,D,I,D,I,D; num_grant_i=num_grant_d=3.
4. D-side write 0x0083 with d_wdata=64'hAAAA_BBBB_CCCC_DDDD -> dataM driven with that value only while writeM=1, high-Z otherwise. doneM reaches d_doneM only.
5. D-side write miss: readM, then writeM with d_readM/d_writeM overlapping by zero gap -> grant stays 10 through both; a pending I request waits until D's request drops.
6. reset_n low while in OWN_D with readM high -> next edge: grant=00, readM=0, all counters 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one block-wide memory port between the I-side and D-side caches.
// The grant is held for a whole transaction. The arbiter also keeps grant and wait statistics.
module mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int READ_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 i_readM,
    input  logic                 i_writeM,
    input  logic [WORD_SIZE-1:0] i_address,
    input  logic [READ_SIZE-1:0] i_wdata,
    output logic [READ_SIZE-1:0] i_rdata,
    output logic                 i_input_readyM,
    output logic                 i_doneM,

    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [READ_SIZE-1:0] d_wdata,
    output logic [READ_SIZE-1:0] d_rdata,
    output logic                 d_input_readyM,
    output logic                 d_doneM,

    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [READ_SIZE-1:0] dataM,
    input  logic                 input_readyM,
    input  logic                 doneM,

    output logic [1:0]           grant,
    output logic [WORD_SIZE-1:0] num_grant_i,
    output logic [WORD_SIZE-1:0] num_grant_d,
    output logic [WORD_SIZE-1:0] num_wait
);

    // State encoding equals the grant code, so grant is the state itself.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    state_t state;
    logic   last_d;
    logic   req_i, req_d;
    logic   wait_hit;
    logic [READ_SIZE-1:0] wdata_sel;

    assign req_i = i_readM | i_writeM;
    assign req_d = d_readM | d_writeM;

    always_comb begin
        wait_hit = 1'b0;
        case (state)
            IDLE:    wait_hit = req_i & req_d;
            OWN_I:   wait_hit = req_d;
            OWN_D:   wait_hit = req_i;
            default: wait_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_d      <= 1'b1;
            num_grant_i <= '0;
            num_grant_d <= '0;
            num_wait    <= '0;
        end else begin
            if (wait_hit)
                num_wait <= num_wait + 1'b1;
            case (state)
                IDLE: begin
                    // On a tie, the side that was not served last wins.
                    if (req_i && (!req_d || last_d)) begin
                        state       <= OWN_I;
                        last_d      <= 1'b0;
                        num_grant_i <= num_grant_i + 1'b1;
                    end else if (req_d) begin
                        state       <= OWN_D;
                        last_d      <= 1'b1;
                        num_grant_d <= num_grant_d + 1'b1;
                    end
                end
                OWN_I:   if (!req_i) state <= IDLE;
                OWN_D:   if (!req_d) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        readM          = 1'b0;
        writeM         = 1'b0;
        address        = '0;
        wdata_sel      = '0;
        i_rdata        = '0;
        i_input_readyM = 1'b0;
        i_doneM        = 1'b0;
        d_rdata        = '0;
        d_input_readyM = 1'b0;
        d_doneM        = 1'b0;
        case (state)
            OWN_I: begin
                readM          = i_readM;
                writeM         = i_writeM;
                address        = i_address;
                wdata_sel      = i_wdata;
                i_rdata        = dataM;
                i_input_readyM = input_readyM;
                i_doneM        = doneM;
            end
            OWN_D: begin
                readM          = d_readM;
                writeM         = d_writeM;
                address        = d_address;
                wdata_sel      = d_wdata;
                d_rdata        = dataM;
                d_input_readyM = input_readyM;
                d_doneM        = doneM;
            end
            default: ;
        endcase
    end

    assign dataM = writeM ? wdata_sel : 'z;
    assign grant = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench itself plays the role of the memory model
// and drives the shared data bus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM, i_writeM, d_readM, d_writeM;
    logic [15:0] i_address, d_address;
    logic [63:0] i_wdata, d_wdata;
    logic [63:0] i_rdata, d_rdata;
    logic        i_input_readyM, i_doneM, d_input_readyM, d_doneM;
    logic        readM, writeM;
    logic [15:0] address;
    wire  [63:0] dataM;
    logic        input_readyM, doneM;
    logic [1:0]  grant;
    logic [15:0] num_grant_i, num_grant_d, num_wait;

    logic        mem_drv;
    logic [63:0] mem_val;
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] PAT   = 64'h5555_5555_5555_5555;
    localparam logic [63:0] RDATA = 64'h0004_0003_0002_0001;
    localparam logic [63:0] WDATA = 64'hAAAA_BBBB_CCCC_DDDD;

    assign dataM = mem_drv ? mem_val : 'z;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(16), .READ_SIZE(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_input_readyM(i_input_readyM), .i_doneM(i_doneM),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_input_readyM(d_input_readyM), .d_doneM(d_doneM),
        .readM(readM), .writeM(writeM), .address(address), .dataM(dataM),
        .input_readyM(input_readyM), .doneM(doneM),
        .grant(grant), .num_grant_i(num_grant_i), .num_grant_d(num_grant_d), .num_wait(num_wait)
    );

    // Both strobes of one side high together is illegal stimulus.
    always @(posedge clk)
        if (reset_n === 1'b1)
            assert (!((i_readM && i_writeM) || (d_readM && d_writeM)))
            else $error("FAIL illegal_strobes i=%b%b d=%b%b required no overlap", i_readM, i_writeM, d_readM, d_writeM);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_readM = 0; i_writeM = 0; d_readM = 0; d_writeM = 0;
        i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
        input_readyM = 0; doneM = 0; mem_drv = 0; mem_val = '0;
        tick(); tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
        checks++; if (readM !== 1'b0 || writeM !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b want 00", readM, writeM); end
        checks++; if (address !== 16'h0) begin errors++; $display("FAIL rst_address got %h want 0000", address); end
        checks++; if ({num_grant_i, num_grant_d, num_wait} !== 48'h0) begin errors++; $display("FAIL rst_counters got %h %h %h want 0", num_grant_i, num_grant_d, num_wait); end
        checks++; if ({i_input_readyM, i_doneM, d_input_readyM, d_doneM} !== 4'b0) begin errors++; $display("FAIL rst_status got %b%b%b%b want 0000", i_input_readyM, i_doneM, d_input_readyM, d_doneM); end
        mem_drv = 1; mem_val = PAT; #1;
        checks++; if (dataM !== PAT) begin errors++; $display("FAIL rst_bus_released got %h want %h", dataM, PAT); end
        checks++; if (i_rdata !== 64'h0 || d_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h %h want 0", i_rdata, d_rdata); end
        mem_drv = 0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        i_readM = 1; i_address = 16'h0040; #1;
        checks++; if (readM !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rd_latency readM=%b grant=%b want 0 00", readM, grant); end
        tick();
        checks++; if (grant !== 2'b01 || readM !== 1'b1) begin errors++; $display("FAIL rd_grant grant=%b readM=%b want 01 1", grant, readM); end
        checks++; if (address !== 16'h0040) begin errors++; $display("FAIL rd_address got %h want 0040", address); end
        checks++; if (num_grant_i !== 16'd1) begin errors++; $display("FAIL rd_num_grant_i got %0d want 1", num_grant_i); end
        mem_drv = 1; mem_val = RDATA; input_readyM = 1; #1;
        checks++; if (i_rdata !== RDATA || i_input_readyM !== 1'b1) begin errors++; $display("FAIL rd_data got %h rdy=%b want %h 1", i_rdata, i_input_readyM, RDATA); end
        checks++; if (d_input_readyM !== 1'b0 || d_rdata !== 64'h0) begin errors++; $display("FAIL rd_no_leak got rdy=%b data=%h want 0 0", d_input_readyM, d_rdata); end
        i_readM = 0; input_readyM = 0; mem_drv = 0;
        tick();
        checks++; if (grant !== 2'b00 || readM !== 1'b0) begin errors++; $display("FAIL rd_release grant=%b readM=%b want 00 0", grant, readM); end
    endtask

    task automatic test_tie_after_reset();
        i_readM = 1; d_readM = 1; i_address = 16'h0100; d_address = 16'h0200;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first got %b want 01", grant); end
        checks++; if (num_wait !== 16'd1) begin errors++; $display("FAIL tie_wait1 got %0d want 1", num_wait); end
        tick();
        checks++; if (num_wait !== 16'd2) begin errors++; $display("FAIL tie_wait2 got %0d want 2", num_wait); end
        i_readM = 0;
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_gap got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b10 || address !== 16'h0200) begin errors++; $display("FAIL tie_second grant=%b addr=%h want 10 0200", grant, address); end
        checks++; if (num_wait !== 16'd3 || num_grant_d !== 16'd1 || num_grant_i !== 16'd1) begin errors++; $display("FAIL tie_counts got w=%0d gd=%0d gi=%0d want 3 1 1", num_wait, num_grant_d, num_grant_i); end
        d_readM = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        i_readM = 1; d_readM = 1;
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++; if (grant !== exp) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, grant, exp); end
            if (exp == 2'b01) i_readM = 0; else d_readM = 0;
            tick();
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_gap%0d got %b want 00", k, grant); end
            if (k < 5) begin
                if (exp == 2'b01) i_readM = 1; else d_readM = 1;
            end
        end
        i_readM = 0;
        tick();
        checks++; if (num_grant_i !== 16'd3 || num_grant_d !== 16'd3) begin errors++; $display("FAIL rr_grants got %0d %0d want 3 3", num_grant_i, num_grant_d); end
        checks++; if (num_wait !== 16'd12) begin errors++; $display("FAIL rr_wait got %0d want 12", num_wait); end
    endtask

    task automatic test_write();
        d_writeM = 1; d_address = 16'h0083; d_wdata = WDATA;
        mem_drv = 1; mem_val = PAT; #1;
        checks++; if (dataM !== PAT || writeM !== 1'b0) begin errors++; $display("FAIL wr_bus_idle got %h wr=%b want %h 0", dataM, writeM, PAT); end
        mem_drv = 0;
        tick();
        checks++; if (grant !== 2'b10 || writeM !== 1'b1 || address !== 16'h0083) begin errors++; $display("FAIL wr_grant g=%b wr=%b a=%h want 10 1 0083", grant, writeM, address); end
        checks++; if (dataM !== WDATA) begin errors++; $display("FAIL wr_data got %h want %h", dataM, WDATA); end
        doneM = 1; #1;
        checks++; if (d_doneM !== 1'b1 || i_doneM !== 1'b0) begin errors++; $display("FAIL wr_done got d=%b i=%b want 1 0", d_doneM, i_doneM); end
        d_writeM = 0; doneM = 0;
        mem_drv = 1; mem_val = PAT; #1;
        checks++; if (dataM !== PAT) begin errors++; $display("FAIL wr_bus_release got %h want %h", dataM, PAT); end
        mem_drv = 0;
        tick();
    endtask

    task automatic test_write_miss();
        d_readM = 1; d_address = 16'h0300; d_wdata = WDATA;
        tick();
        checks++; if (grant !== 2'b10 || readM !== 1'b1) begin errors++; $display("FAIL wm_read g=%b rd=%b want 10 1", grant, readM); end
        i_readM = 1; i_address = 16'h0400;
        tick();
        d_readM = 0; d_writeM = 1;
        tick();
        checks++; if (grant !== 2'b10 || writeM !== 1'b1 || readM !== 1'b0) begin errors++; $display("FAIL wm_write g=%b wr=%b rd=%b want 10 1 0", grant, writeM, readM); end
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wm_hold got %b want 10", grant); end
        d_writeM = 0;
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wm_release got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b01 || address !== 16'h0400) begin errors++; $display("FAIL wm_i_grant g=%b a=%h want 01 0400", grant, address); end
        checks++; if (num_wait !== 16'd4 || num_grant_d !== 16'd1 || num_grant_i !== 16'd1) begin errors++; $display("FAIL wm_counts w=%0d gd=%0d gi=%0d want 4 1 1", num_wait, num_grant_d, num_grant_i); end
        i_readM = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_readM = 1; d_address = 16'h0500;
        tick();
        checks++; if (grant !== 2'b10 || readM !== 1'b1 || num_grant_d !== 16'd1) begin errors++; $display("FAIL mid_own g=%b rd=%b gd=%0d want 10 1 1", grant, readM, num_grant_d); end
        reset_n = 0;
        tick();
        checks++; if (grant !== 2'b00 || readM !== 1'b0) begin errors++; $display("FAIL mid_reset g=%b rd=%b want 00 0", grant, readM); end
        checks++; if ({num_grant_i, num_grant_d, num_wait} !== 48'h0) begin errors++; $display("FAIL mid_counters got %h %h %h want 0", num_grant_i, num_grant_d, num_wait); end
        d_readM = 0;
        reset_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reset();
        test_tie_after_reset();
        test_reset();
        test_round_robin();
        test_reset();
        test_write();
        test_reset();
        test_write_miss();
        test_reset();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
